// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   fetch_state_t : FSM state encoding (FETCH / WAIT / READY / DRAIN)
//   INSN_BUBBLE   : instruction value presented when nothing valid is held;
//                   matches what the IF/ID register loads on a flush
//   PC_STEP       : sequential PC increment in bytes
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INSN_BUBBLE = 32'h0000_0000;
    localparam logic [63:0] PC_STEP     = 64'd4;

endpackage

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage feeding the IF/ID register. Keeps the program
// counter, issues one instruction-memory request at a time and presents the
// fetched pc/instruction pair, holding it while the IF/ID register is stalled.
// A redirect from EX abandons any in-flight fetch and restarts at the target.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   redirect     in   change of control flow (highest priority)
//   redirect_pc  in   new fetch target, low two bits ignored
//   if_write     in   IF/ID write enable (0 = stall)
//   imem_req     out  request strobe (one cycle per request)
//   imem_addr    out  request address (internal PC)
//   imem_valid   in   response strobe
//   imem_rdata   in   instruction word, valid with imem_valid
//   pc           out  PC of the presented instruction
//   instruction  out  presented instruction, bubble when not valid
//   fetch_valid  out  pc/instruction hold a real fetched instruction
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        if_write,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [63:0] pc,
    output logic [31:0] instruction,
    output logic        fetch_valid
);

    fetch_state_t state_reg, state_next;
    logic [63:0]  pc_reg, pc_next;
    logic [63:0]  pc_out_reg, pc_out_next;
    logic [31:0]  insn_reg, insn_next;
    logic         valid_reg, valid_next;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= FETCH;
            pc_reg     <= RESET_PC;
            pc_out_reg <= 64'h0;
            insn_reg   <= INSN_BUBBLE;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            pc_out_reg <= pc_out_next;
            insn_reg   <= insn_next;
            valid_reg  <= valid_next;
        end
    end

    // Next-state logic. A redirect must go to DRAIN whenever a request is
    // still outstanding after this edge, so the stale response is swallowed
    // rather than mistaken for the new target's instruction.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH: state_next = redirect ? DRAIN : WAIT;
            WAIT: begin
                if (imem_valid)
                    state_next = redirect ? FETCH : READY;
                else
                    state_next = redirect ? DRAIN : WAIT;
            end
            READY: begin
                if (redirect || if_write)
                    state_next = FETCH;
            end
            DRAIN: begin
                if (imem_valid)
                    state_next = FETCH;
            end
            default: state_next = FETCH;
        endcase
    end

    // Datapath next values: PC and the presented pc/instruction/valid.
    always_comb begin
        pc_next     = pc_reg;
        pc_out_next = pc_out_reg;
        insn_next   = insn_reg;
        valid_next  = valid_reg;
        if (redirect) begin
            pc_next    = redirect_pc & ~64'h3;
            insn_next  = INSN_BUBBLE;
            valid_next = 1'b0;
        end else if (state_reg == WAIT && imem_valid) begin
            pc_out_next = pc_reg;
            insn_next   = imem_rdata;
            valid_next  = 1'b1;
            pc_next     = pc_reg + PC_STEP;   // wraps modulo 2^64
        end else if (state_reg == READY && if_write) begin
            // Instruction consumed by IF/ID; pc is left as-is.
            insn_next  = INSN_BUBBLE;
            valid_next = 1'b0;
        end
    end

    // Outputs: request is purely a function of state.
    always_comb begin
        imem_req    = (state_reg == FETCH);
        imem_addr   = pc_reg;
        pc          = pc_out_reg;
        instruction = insn_reg;
        fetch_valid = valid_reg;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. A behavioural instruction memory with
// adjustable latency answers the main instance; a second instance with
// RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC and a fixed 1-cycle memory covers PC
// wrap-around. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        if_write = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [63:0] pc;
    logic [31:0] instruction;
    logic        fetch_valid;

    // Wrap-test instance signals
    logic        w_req;
    logic [63:0] w_addr;
    logic        w_valid;
    logic [31:0] w_rdata;
    logic [63:0] w_pc;
    logic [31:0] w_insn;
    logic        w_fvalid;
    logic        w_redirect = 1'b0;
    logic [63:0] w_redirect_pc = 64'h0;
    logic        w_if_write = 1'b1;

    int errors = 0;
    int checks = 0;
    int mem_lat = 1;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(64'h0)) dut (
        .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_write(if_write), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .pc(pc),
        .instruction(instruction), .fetch_valid(fetch_valid)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .if_write(w_if_write), .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(w_valid), .imem_rdata(w_rdata), .pc(w_pc),
        .instruction(w_insn), .fetch_valid(w_fvalid)
    );

    // Memory contents: the two test-plan words at 0 and 4, an address-tagged
    // pattern everywhere else so a wrong fetch is visible in the data.
    function automatic logic [31:0] word(input logic [63:0] a);
        if (a == 64'h0)      return 32'h0050_0093;
        else if (a == 64'h4) return 32'h00A0_0113;
        else                 return {a[23:0], 8'h13};
    endfunction

    // Main memory model: the response strobe comes mem_lat cycles after the
    // cycle in which imem_req was high.
    logic        m_pend;
    int          m_cnt;
    logic [63:0] m_addr;
    always @(posedge clk) begin
        if (reset) begin
            m_pend     <= 1'b0;
            imem_valid <= 1'b0;
            imem_rdata <= 32'h0;
        end else begin
            imem_valid <= 1'b0;
            if (m_pend) begin
                if (m_cnt == 0) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= word(m_addr);
                    m_pend     <= 1'b0;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
            if (imem_req) begin
                if (mem_lat == 1) begin
                    imem_valid <= 1'b1;
                    imem_rdata <= word(imem_addr);
                end else begin
                    m_pend <= 1'b1;
                    m_cnt  <= mem_lat - 2;
                    m_addr <= imem_addr;
                end
            end
        end
    end

    // Wrap-instance memory: fixed 1-cycle latency.
    always @(posedge clk) begin
        if (reset) w_valid <= 1'b0;
        else       w_valid <= w_req;
        w_rdata <= word(w_addr);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive the inputs for the current cycle, then move to 1 unit after the
    // next rising edge.
    task automatic step(input logic r, input logic [63:0] rp, input logic w);
        redirect    = r;
        redirect_pc = rp;
        if_write    = w;
        @(posedge clk);
        #1;
        redirect    = 1'b0;
    endtask

    // Leaves the bench in cycle 0: the first cycle with reset low.
    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        if_write = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        redir;
        logic [63:0] rpc;
        logic        ifw;
        logic        req;
        logic [63:0] addr;
        logic        vld;
        logic [63:0] pc;
        logic [31:0] insn;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Basic fetch (rows 0-7) followed by a 5-cycle stall at pc = 8.
        // Each row: inputs for that cycle, expected outputs in that cycle.
        tbl[0]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h0,  1'b0, 64'h0, 32'h0};
        tbl[1]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h0,  1'b0, 64'h0, 32'h0};
        tbl[2]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h4,  1'b1, 64'h0, 32'h0050_0093};
        tbl[3]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h4,  1'b0, 64'h0, 32'h0};
        tbl[4]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h4,  1'b0, 64'h0, 32'h0};
        tbl[5]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h8,  1'b1, 64'h4, 32'h00A0_0113};
        tbl[6]  = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h8,  1'b0, 64'h4, 32'h0};
        tbl[7]  = '{1'b0, 64'h0, 1'b1, 1'b0, 64'h8,  1'b0, 64'h4, 32'h0};
        for (int i = 8; i <= 12; i++)
            tbl[i] = '{1'b0, 64'h0, 1'b0, 1'b0, 64'hC, 1'b1, 64'h8, 32'h0000_0813};
        tbl[13] = '{1'b0, 64'h0, 1'b1, 1'b0, 64'hC,  1'b1, 64'h8, 32'h0000_0813};
        tbl[14] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'hC,  1'b0, 64'h8, 32'h0};

        // Reset values, checked while reset is still asserted.
        @(posedge clk);
        #1;
        chk("rst_req",   {63'h0, imem_req},    64'h1);
        chk("rst_addr",  imem_addr,            64'h0);
        chk("rst_pc",    pc,                   64'h0);
        chk("rst_insn",  {32'h0, instruction}, 64'h0);
        chk("rst_valid", {63'h0, fetch_valid}, 64'h0);

        // ---------------- table: basic fetch + stall ----------------
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("row%0d_req", i),   {63'h0, imem_req},    {63'h0, tbl[i].req});
            chk($sformatf("row%0d_addr", i),  imem_addr,            tbl[i].addr);
            chk($sformatf("row%0d_valid", i), {63'h0, fetch_valid}, {63'h0, tbl[i].vld});
            chk($sformatf("row%0d_pc", i),    pc,                   tbl[i].pc);
            chk($sformatf("row%0d_insn", i),  {32'h0, instruction}, {32'h0, tbl[i].insn});
            $display("row %0d: req=%0b addr=%h valid=%0b pc=%h insn=%h",
                     i, imem_req, imem_addr, fetch_valid, pc, instruction);
            step(tbl[i].redir, tbl[i].rpc, tbl[i].ifw);
        end

        // ---------------- redirect in READY, then in WAIT (latency 3) ----------------
        mem_lat = 1;
        do_reset();
        step(1'b0, 64'h0, 1'b1);                       // c0 FETCH 0
        step(1'b0, 64'h0, 1'b1);                       // c1 WAIT, response
        chk("rdy_valid", {63'h0, fetch_valid}, 64'h1); // c2 READY
        step(1'b1, 64'h10, 1'b0);                      // c2 redirect -> 0x10
        chk("rdir_ready_req",  {63'h0, imem_req}, 64'h1);   // c3 FETCH 0x10
        chk("rdir_ready_addr", imem_addr, 64'h10);
        mem_lat = 3;
        step(1'b0, 64'h0, 1'b1);                       // c3 request 0x10
        step(1'b1, 64'h100, 1'b1);                     // c4 WAIT: redirect -> 0x100
        chk("drain_req",  {63'h0, imem_req}, 64'h0);   // c5 DRAIN
        chk("drain_addr", imem_addr, 64'h100);
        chk("drain_valid5", {63'h0, fetch_valid}, 64'h0);
        step(1'b0, 64'h0, 1'b1);                       // c5 DRAIN, no response
        chk("drain_hold_req", {63'h0, imem_req}, 64'h0);
        chk("drain_valid6", {63'h0, fetch_valid}, 64'h0);
        step(1'b0, 64'h0, 1'b1);                       // c6 stale 0x10 response
        chk("after_drain_req",  {63'h0, imem_req}, 64'h1);  // c7 FETCH 0x100
        chk("after_drain_addr", imem_addr, 64'h100);
        chk("drain_valid7", {63'h0, fetch_valid}, 64'h0);
        mem_lat = 1;
        step(1'b0, 64'h0, 1'b1);                       // c7
        chk("drain_valid8", {63'h0, fetch_valid}, 64'h0);
        step(1'b0, 64'h0, 1'b1);                       // c8 WAIT, response
        chk("tgt_valid", {63'h0, fetch_valid}, 64'h1); // c9 READY
        chk("tgt_pc",    pc, 64'h100);
        chk("tgt_insn",  {32'h0, instruction}, {32'h0, word(64'h100)});
        $display("redirect-in-WAIT: pc=%h insn=%h", pc, instruction);

        // ---------------- redirect with imem_valid in WAIT ----------------
        step(1'b0, 64'h0, 1'b1);                       // c9 consume
        chk("seq_addr", imem_addr, 64'h104);           // c10 FETCH 0x104
        step(1'b0, 64'h0, 1'b1);                       // c10
        step(1'b1, 64'h203, 1'b1);                     // c11 WAIT + valid + redirect
        chk("wv_req",   {63'h0, imem_req}, 64'h1);     // c12 FETCH 0x200, no DRAIN
        chk("wv_addr",  imem_addr, 64'h200);
        chk("wv_valid", {63'h0, fetch_valid}, 64'h0);
        chk("wv_insn",  {32'h0, instruction}, 64'h0);
        step(1'b0, 64'h0, 1'b1);                       // c12
        step(1'b0, 64'h0, 1'b1);                       // c13
        chk("wv_tgt_pc",   pc, 64'h200);               // c14 READY
        chk("wv_tgt_insn", {32'h0, instruction}, {32'h0, word(64'h200)});
        $display("redirect-with-valid: pc=%h insn=%h", pc, instruction);

        // ---------------- redirect in READY with if_write = 1 ----------------
        step(1'b1, 64'h103, 1'b1);                     // c14 redirect -> 0x103
        chk("rr_req",   {63'h0, imem_req}, 64'h1);     // c15 FETCH 0x100
        chk("rr_addr",  imem_addr, 64'h100);
        chk("rr_valid", {63'h0, fetch_valid}, 64'h0);
        chk("rr_insn",  {32'h0, instruction}, 64'h0);
        $display("redirect-in-READY: addr=%h", imem_addr);

        // ---------------- PC wrap (second instance) ----------------
        mem_lat = 1;
        do_reset();
        chk("wrap_addr0", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_req0",  {63'h0, w_req}, 64'h1);
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        chk("wrap_pc",    w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_valid", {63'h0, w_fvalid}, 64'h1);
        step(1'b0, 64'h0, 1'b1);
        chk("wrap_req3",  {63'h0, w_req}, 64'h1);
        chk("wrap_addr3", w_addr, 64'h0);
        $display("wrap: second fetch addr=%h", w_addr);

        // ---------------- reset while in DRAIN ----------------
        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 1'b1);   // c0..c4
        chk("pre_pc", pc, 64'h4);                      // c5 READY pc 4
        mem_lat = 3;
        step(1'b1, 64'h40, 1'b0);                      // c5 redirect -> 0x40
        step(1'b1, 64'h80, 1'b1);                      // c6 FETCH + redirect -> DRAIN
        chk("mr_drain_req",  {63'h0, imem_req}, 64'h0);// c7 DRAIN
        chk("mr_drain_addr", imem_addr, 64'h80);
        chk("mr_drain_pc",   pc, 64'h4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mr_pc",    pc, 64'h0);
        chk("mr_insn",  {32'h0, instruction}, 64'h0);
        chk("mr_valid", {63'h0, fetch_valid}, 64'h0);
        chk("mr_req",   {63'h0, imem_req}, 64'h1);
        chk("mr_addr",  imem_addr, 64'h0);
        reset   = 1'b0;
        mem_lat = 1;
        step(1'b0, 64'h0, 1'b1);
        step(1'b0, 64'h0, 1'b1);
        chk("mr_restart_valid", {63'h0, fetch_valid}, 64'h1);
        chk("mr_restart_pc",    pc, 64'h0);
        chk("mr_restart_insn",  {32'h0, instruction}, 64'h0050_0093);
        $display("mid-op reset: restart pc=%h insn=%h", pc, instruction);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the IF/ID pipeline register: it keeps the program counter, issues one instruction-memory request at a time, and presents the fetched `pc`/`instruction` pair. It holds that pair on its outputs while the hazard unit stalls (`if_write` = 0). On a branch or jump `redirect` it discards any in-flight fetch and restarts at the new target. It sits between the instruction memory and `if_id_register`.

## Interface
- `RESET_PC`, default 64'h0: PC fetched first after reset.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `redirect`  in  1  change of control flow from EX; highest priority.
- `redirect_pc`  in  64  new fetch target; bits [1:0] forced to 0 on capture.
- `if_write`  in  1  IF/ID write enable (0 = stall); same signal the IF/ID register uses.
- `imem_req`  out  1  request strobe, one cycle per request.
- `imem_addr`  out  64  request address, equal to the internal `pc_q`.
- `imem_valid`  in  1  response strobe, at least 1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word, valid with `imem_valid`.
- `pc`  out  64  PC of the presented instruction.
- `instruction`  out  32  presented instruction; 32'h0 (bubble) when not valid.
- `fetch_valid`  out  1  `pc`/`instruction` hold a real fetched instruction.

## Operation
- States:
  - FETCH: `imem_req` = 1 and `imem_addr` = `pc_q`, driven combinationally from state. Always goes to WAIT next cycle.
  - WAIT: waits for `imem_valid`. When it arrives: `instruction` ← `imem_rdata`, `pc` ← `pc_q`, `fetch_valid` ← 1, `pc_q` ← `pc_q` + 4, go to READY.
  - READY: outputs held stable. If `if_write` = 1: go to FETCH, `fetch_valid` ← 0, `instruction` ← 0. If `if_write` = 0: stay in READY.
  - DRAIN: waits for the `imem_valid` of an abandoned request, discards `imem_rdata`, then goes to FETCH.
- Redirect overrides everything else in the same cycle:
  - `pc_q` ← {`redirect_pc`[63:2], 2'b00}; `fetch_valid` ← 0; `instruction` ← 0.
  - FETCH → DRAIN, because the request issued this cycle is outstanding.
  - WAIT without `imem_valid` → DRAIN.
  - WAIT with `imem_valid` → FETCH; the response is discarded.
  - READY → FETCH; the held instruction is dropped even if `if_write` = 1.
  - DRAIN without `imem_valid` → stay in DRAIN with the newest target.
  - DRAIN with `imem_valid` → FETCH.
- `imem_valid` in FETCH or READY is ignored.
- At most one outstanding request at any time.
- PC arithmetic is 64-bit modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - state FETCH, `pc_q` = `RESET_PC`.
  - `pc` = 0, `instruction` = 0, `fetch_valid` = 0.
  - `imem_req` = 1 in the first cycle after reset deasserts, since it is combinational from FETCH.
- Reset mid-operation aborts everything. The memory is reset by the same `reset`, so no stale response is expected.
- Latency with 1-cycle memory:
  - request in cycle n, response in n+1, `fetch_valid` high in n+2, next request in n+3 if `if_write` = 1 in n+2.
  - Steady-state throughput is 1 instruction per 3 cycles.
- `fetch_valid`, `pc` and `instruction` are registered; they change only on `clk` edges.
- While READY with `if_write` = 0 they stay bit-for-bit constant.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum {FETCH, WAIT, READY, DRAIN};
  - `INSN_BUBBLE` = 32'h0000_0000 (the same value the IF/ID register loads on flush);
  - `PC_STEP` = 4.
- Single module. No sub-module: the PC register and FSM are too tightly coupled to split.

## Test plan
- Basic fetch: `RESET_PC` = 0, memory latency 1, `if_write` = 1, words 0x00500093 / 0x00A00113 → `imem_addr` sequence 0, 4. Outputs (`pc` = 0, `instruction` = 0x00500093) with `fetch_valid` = 1 in cycle 2, then `pc` = 4 in cycle 5.
- Stall: hold `if_write` = 0 for 5 cycles while READY with `pc` = 8 → outputs constant, `imem_req` = 0 throughout. One cycle after `if_write` = 1: `fetch_valid` = 0, `imem_req` = 1, `imem_addr` = 12.
- Redirect in WAIT: memory latency 3, `redirect` with `redirect_pc` = 0x100 one cycle after request to 0x10 → state goes to DRAIN and the 0x10 response is discarded. Next `imem_addr` = 0x100, and no instruction from 0x10 ever shows `fetch_valid` = 1.
- Redirect in the same cycle as `imem_valid` in WAIT, and redirect in READY with `if_write` = 1 → no DRAIN; the next cycle fetches `redirect_pc`. Misaligned `redirect_pc` = 0x103 yields `imem_addr` = 0x100.
- PC wrap and mid-operation reset: `RESET_PC` = 64'hFFFF_FFFF_FFFF_FFFC → second fetch uses `imem_addr` = 0. Asserting `reset` while in DRAIN returns all outputs to their reset values and restarts the fetch at `RESET_PC`.
